fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//   Control FSM for one FIR filter channel. Accepts one input sample per valid/ready handshake.
//   Pulses the enable of the D_FF delay-line chain to shift in the sample.
//   Then steps tap_sel through every tap, driving the MAC clear/enable/last strobes.
//   Presents the finished result with an out_valid/out_ready handshake.
//   Sits between the sample source and the delay-line / coefficient-ROM / MAC datapath; carries no data itself.
// PARAMETERS
//   NUM_TAPS   16   taps per filter (>=1); TAP_AW = $clog2(NUM_TAPS), min 1, is a localparam
// PORTS
//   clk        in   1       system clock, all state on posedge
//   rst        in   1       asynchronous, active-high reset
//   in_valid   in   1       source has a sample
//   in_ready   out  1       sequencer can accept a sample (IDLE only; forced 0 while rst=1)
//   shift_en   out  1       enable to delay-line D_FFs; = in_valid & in_ready (same-cycle capture)
//   tap_sel    out  TAP_AW  tap mux select / coefficient ROM address
//   mac_en     out  1       MAC accumulates this cycle
//   mac_clr    out  1       MAC loads product instead of adding (first tap)
//   mac_last   out  1       final tap of this sample
//   out_valid  out  1       accumulator holds a finished result
//   out_ready  in   1       consumer takes result
//   busy       out  1       state != IDLE
//   stall_cnt  out  16      only with FIR_SEQ_STALL_CNT_EN
// BEHAVIOUR
//   Reset: state=IDLE, tap_sel=0, mac_en=mac_clr=mac_last=out_valid=0, busy=0, stall_cnt=0.
//   Outputs are registered except in_ready/shift_en, which are decoded from state and in_valid.
//   IDLE: in_ready=1. On in_valid=1 -> shift_en=1 that cycle, next MAC with tap_sel=0.
//   MAC: mac_en=1 for exactly NUM_TAPS cycles, tap_sel 0..NUM_TAPS-1 (one per cycle).
//     mac_clr=1 only when tap_sel==0; mac_last=1 only when tap_sel==NUM_TAPS-1.
//     After the last tap -> DONE; tap_sel returns to 0.
//   DONE: out_valid=1, held stable until out_ready=1. The handshake cycle -> IDLE; out_valid=0 next cycle.
//   Timing (accept on edge 0): MAC cycles 1..NUM_TAPS, out_valid from cycle NUM_TAPS+1.
//     Max throughput is one sample per NUM_TAPS+2 cycles.
//   in_valid outside IDLE is ignored: no shift_en; the source must hold the sample.
//   out_ready while out_valid=0 is ignored.
//   NUM_TAPS=1: single MAC cycle with mac_clr and mac_last both high.
//   rst mid-operation: immediate return to reset values. The in-flight sample is dropped.
//     The datapath is reset by the same rst.
//   Illegal state encoding -> IDLE.
// CONFIGURATION
//   `FIR_SEQ_STALL_CNT_EN defined:
//     stall_cnt port exists. It increments each cycle with out_valid=1 & out_ready=0.
//     It saturates at 16'hFFFF and clears only on rst.
//   Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   fir_seq_pkg holds:
//     typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} fir_seq_state_t
//     localparam STALL_CNT_W = 16
//   Sub-module fir_seq_tap_cnt holds:
//     TAP_AW up-counter with load-zero, enable, first/last flags; supplies tap_sel/mac_clr/mac_last.
// TESTING (NUM_TAPS=4)
//   Reset, then in_valid=1 on edge 0:
//     shift_en=1 in cycle 0 only; cycles 1-4 mac_en=1, tap_sel=0,1,2,3; mac_clr cycle 1; mac_last cycle 4.
//   out_ready held 0 for 5 cycles after out_valid rises:
//     out_valid stays 1; in_ready=0; stall_cnt=5 (macro on); next sample accepted only after the handshake.
//   Back-to-back in_valid with out_ready=1:
//     accepts on cycles 0, 6, 12; exactly one shift_en per sample; no in_valid accepted during MAC/DONE.
//   rst asserted at tap_sel=2:
//     all outputs 0 immediately; after release in_ready=1, the next sample gives a fresh tap_sel 0..3 sequence.
//   Counter saturation (macro on): force 70000 stall cycles -> stall_cnt=16'hFFFF, no wrap.
//   Recompile with NUM_TAPS=1: each sample gives one mac_en cycle with mac_clr=mac_last=1; out_valid next cycle.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR tap sequencer.
// Holds the FSM state encoding and the stall counter width.
package fir_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_DONE
   } fir_seq_state_t;

   localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fir_seq_tap_cnt.sv
// Tap index counter for the FIR sequencer.
// Produces the tap select plus registered first/last tap flags.
module fir_seq_tap_cnt #(
   parameter int NUM_TAPS = 16,
   parameter int TAP_AW   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   output logic [TAP_AW-1:0] tap,
   output logic              first,
   output logic              last
);

   localparam logic [TAP_AW-1:0] LAST_TAP = TAP_AW'(NUM_TAPS - 1);

   logic [TAP_AW-1:0] tap_nxt;

   assign tap_nxt = tap + TAP_AW'(1);

   // Load starts at tap 0; each step advances, the final step parks at 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tap   <= '0;
         first <= 1'b0;
         last  <= 1'b0;
      end else if (load) begin
         tap   <= '0;
         first <= 1'b1;
         last  <= (LAST_TAP == '0);
      end else if (step) begin
         if (last) begin
            tap   <= '0;
            first <= 1'b0;
            last  <= 1'b0;
         end else begin
            tap   <= tap_nxt;
            first <= 1'b0;
            last  <= (tap_nxt == LAST_TAP);
         end
      end
   end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Control FSM for one FIR channel: accept, step taps, present result.
// Optional FIR_SEQ_STALL_CNT_EN adds a saturating output stall counter.
module fir_tap_sequencer
   import fir_seq_pkg::*;
#(
   parameter int NUM_TAPS = 16,
   localparam int TAP_AW  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   shift_en,
   output logic [TAP_AW-1:0]      tap_sel,
   output logic                   mac_en,
   output logic                   mac_clr,
   output logic                   mac_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy
`ifdef FIR_SEQ_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   fir_seq_state_t state, state_n;
   logic           load, step;
   logic           first, last;

   fir_seq_tap_cnt #(
      .NUM_TAPS(NUM_TAPS),
      .TAP_AW  (TAP_AW)
   ) u_tap_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .step (step),
      .tap  (tap_sel),
      .first(first),
      .last (last)
   );

   assign mac_clr  = first;
   assign mac_last = last;
   assign in_ready = (state == S_IDLE) & ~rst;
   assign shift_en = in_valid & in_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next-state decode and counter control
   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               state_n = S_MAC;
               load    = 1'b1;
            end
         end
         S_MAC: begin
            step = 1'b1;
            if (last) state_n = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Registered status outputs follow the upcoming state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mac_en    <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         mac_en    <= (state_n == S_MAC);
         out_valid <= (state_n == S_DONE);
         busy      <= (state_n != S_IDLE);
      end
   end

`ifdef FIR_SEQ_STALL_CNT_EN
   // Count cycles where a result waits on the consumer, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != '1))
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer (NUM_TAPS=4 and NUM_TAPS=1).
// Stall counter checks run when FIR_SEQ_STALL_CNT_EN is defined.
module tb_fir_tap_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, out_ready;
   logic       in_ready, shift_en, mac_en, mac_clr, mac_last, out_valid, busy;
   logic [1:0] tap_sel;

   logic       in_valid1, out_ready1;
   logic       in_ready1, shift_en1, mac_en1, mac_clr1, mac_last1;
   logic       out_valid1, busy1;
   logic [0:0] tap_sel1;

`ifdef FIR_SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt, stall_cnt1;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fir_tap_sequencer #(.NUM_TAPS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .shift_en (shift_en),
      .tap_sel  (tap_sel),
      .mac_en   (mac_en),
      .mac_clr  (mac_clr),
      .mac_last (mac_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy     (busy)
`ifdef FIR_SEQ_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   fir_tap_sequencer #(.NUM_TAPS(1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid1),
      .in_ready (in_ready1),
      .shift_en (shift_en1),
      .tap_sel  (tap_sel1),
      .mac_en   (mac_en1),
      .mac_clr  (mac_clr1),
      .mac_last (mac_last1),
      .out_valid(out_valid1),
      .out_ready(out_ready1),
      .busy     (busy1)
`ifdef FIR_SEQ_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt1)
`endif
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_valid1  = 1'b0;
      out_ready1 = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_tap", tap_sel, 0);
      chk("rst_mac_en", mac_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      step();
      rst = 1'b0;

      // first sample, held result for 5 stall cycles
      in_valid = 1'b1;
      @(negedge clk);
      chk("c0_in_ready", in_ready, 1);
      chk("c0_shift_en", shift_en, 1);
      step();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("mac%0d_shift", k), shift_en, 0);
         chk($sformatf("mac%0d_en", k), mac_en, 1);
         chk($sformatf("mac%0d_tap", k), tap_sel, k - 1);
         chk($sformatf("mac%0d_clr", k), mac_clr, (k == 1) ? 1 : 0);
         chk($sformatf("mac%0d_last", k), mac_last, (k == 4) ? 1 : 0);
         chk($sformatf("mac%0d_busy", k), busy, 1);
         step();
      end
      for (int k = 5; k <= 9; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_ov", k), out_valid, 1);
         chk($sformatf("stall%0d_rdy", k), in_ready, 0);
         chk($sformatf("stall%0d_shift", k), shift_en, 0);
         chk($sformatf("stall%0d_mac", k), mac_en, 0);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("hs_ov", out_valid, 1);
`ifdef FIR_SEQ_STALL_CNT_EN
      chk("stall_cnt5", stall_cnt, 5);
`endif
      step();

      // back-to-back: accepts at relative cycles 0, 6, 12
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         chk($sformatf("b2b%0d_shift", c), shift_en, (c % 6 == 0) ? 1 : 0);
         chk($sformatf("b2b%0d_ov", c), out_valid, (c % 6 == 5) ? 1 : 0);
         if ((c % 6) >= 1 && (c % 6) <= 4)
            chk($sformatf("b2b%0d_tap", c), tap_sel, (c % 6) - 1);
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_end_rdy", in_ready, 1);
      chk("b2b_end_busy", busy, 0);
`ifdef FIR_SEQ_STALL_CNT_EN
      chk("b2b_stall_cnt", stall_cnt, 5);
`endif
      step();

      // reset in the middle of the tap sweep
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("mid_tap2", tap_sel, 2);
      in_valid = 1'b1;
      rst = 1'b1;
      #1;
      chk("mrst_tap", tap_sel, 0);
      chk("mrst_mac_en", mac_en, 0);
      chk("mrst_clr", mac_clr, 0);
      chk("mrst_last", mac_last, 0);
      chk("mrst_ov", out_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_rdy", in_ready, 0);
      chk("mrst_shift", shift_en, 0);
`ifdef FIR_SEQ_STALL_CNT_EN
      chk("mrst_stall", stall_cnt, 0);
`endif
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rdy", in_ready, 1);
      chk("post_shift", shift_en, 1);
      step();
      in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("post%0d_tap", k), tap_sel, k - 1);
         chk($sformatf("post%0d_clr", k), mac_clr, (k == 1) ? 1 : 0);
         step();
      end
      @(negedge clk);
      chk("post_ov", out_valid, 1);
      step();

`ifdef FIR_SEQ_STALL_CNT_EN
      // saturation of the stall counter
      in_valid  = 1'b1;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      repeat (4 + 70000) step();
      @(negedge clk);
      chk("sat_ov", out_valid, 1);
      chk("sat_cnt", stall_cnt, 16'hFFFF);
      out_ready = 1'b1;
      step();
      step();
`endif

      // single-tap instance
      in_valid1  = 1'b1;
      out_ready1 = 1'b1;
      @(negedge clk);
      chk("t1_shift", shift_en1, 1);
      step();
      in_valid1 = 1'b0;
      @(negedge clk);
      chk("t1_mac_en", mac_en1, 1);
      chk("t1_clr", mac_clr1, 1);
      chk("t1_last", mac_last1, 1);
      chk("t1_tap", tap_sel1, 0);
      chk("t1_ov0", out_valid1, 0);
      step();
      @(negedge clk);
      chk("t1_ov1", out_valid1, 1);
      chk("t1_mac_off", mac_en1, 0);
      step();
      @(negedge clk);
      chk("t1_ov_end", out_valid1, 0);
      chk("t1_rdy", in_ready1, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
